mealy_seq_detector: RTL and testbench
=====================================

# mealy_seq_detector

Parametrised serial pattern detector, the successor of the two-state Mealy edge detector in the FSM lab. It scans a gated 1-bit input stream for a compile-time W-bit pattern and supports overlapping or non-overlapping matching. It provides a combinational Mealy match pulse, a registered copy of that pulse, and a saturating match counter. It sits between an input synchroniser or strobe generator and the board LED/7-segment display logic.

## Interface

Reset: one clock; reset is asynchronous and active-low.

Parameters:
- `W`, default 4: pattern length in bits. Legal range 2..16.
- `PATTERN`, default 4'b1011: W-bit pattern. Bit W-1 is the oldest input bit; bit 0 is the newest.
- `OVERLAP`, default 1: 1 = overlapping matches allowed; 0 = the detector restarts after every match.
- `CNT_W`, default 8: width of the match counter. Legal range 1..32.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `en`  in  1  sample enable. `a` is consumed only in cycles with `en`=1.
- `a`  in  1  serial data bit.
- `clear`  in  1  synchronous clear of history, fill and counter.
- `y`  out  1  Mealy match. Combinational from the current state, `a`, `en` and `clear`.
- `y_q`  out  1  `y` registered; lags `y` by one cycle.
- `count`  out  CNT_W  number of matches, saturating.
- `sat`  out  1  high while `count` is all-ones.

## Operation

State:
- `hist[W-2:0]`: the last W-1 consumed bits, newest in the LSB.
- `fill`: counts valid history bits, range 0..W-1.

Match rule:
- `y` = `en` & ~`clear` & (`fill`==W-1) & ({`hist`,`a`}==`PATTERN`).

On a clock edge with `clear`=1 (clear has priority over `en`):
- `fill`, `hist` and `count` go to 0.
- `y_q` goes to 0.

On a clock edge with `clear`=0 and `en`=1:
- `hist` <= {`hist`[W-3:0], `a`}. For W=2, `hist` <= `a`.
- `fill` <= min(`fill`+1, W-1).
- If `y`=1 and `OVERLAP`=0, `fill` <= 0 instead; `hist` still shifts.
- If `y`=1 and `count` is below all-ones, `count` <= `count`+1. At all-ones, `count` holds.

On a clock edge with `clear`=0 and `en`=0:
- `hist`, `fill` and `count` hold.
- `y` is 0 in that cycle.

Every clock edge (unless `clear`=1): `y_q` <= `y`.

`sat` = (`count` == {CNT_W{1'b1}}). It is combinational from `count`.

Reset (`reset_n`=0, asynchronous, takes effect immediately):
- `hist`=0, `fill`=0, `count`=0, `y_q`=0.
- Therefore `y`=0 and `sat`=0, since CNT_W≥1.
- Reset asserted mid-stream discards any partial match. The first match is possible only after W consumed bits.

## Timing

- `y` is valid in the same cycle as the W-th matching bit. There is no register on this path.
- `y_q` and `count` update on the following clock edge. The `count` increment is visible one cycle after `y`.
- In non-overlap mode, the next match needs W fresh consumed bits after the matching bit.
- `en` gaps of any length do not break a partial match.
- The reset release is synchronised outside this block. The first edge after release may already consume a bit.

## Structure

- Shared package `seq_det_pkg`:
  - Localparam helper `FILL_W` = $clog2(W).
  - Parameter legality checks, as elaboration-time assertions.
- One natural sub-module, `sat_counter #(CNT_W)`, with ports clk, reset_n, clear, inc, count, sat. It is reused by later display blocks.
- The detector core (history shift register, fill counter, compare logic) stays in `mealy_seq_detector`.

## Test plan

1. **Overlap.** Defaults, `en`=1, `a` = 1,0,1,1,0,1,1 → `y`=1 on bits 4 and 7 only; `count`=2 two cycles after bit 7; `y_q` follows `y` one cycle later.
2. **Non-overlap.** `OVERLAP`=0, same stream → `y`=1 on bit 4 only; `count`=1. With `PATTERN`=4'b1111 and six 1s → one match, on bit 4.
3. **Enable gaps.** Stream 1,0,1,1 with `en`=0 for 3 cycles between each bit (`a` toggling randomly while `en`=0) → single `y` pulse on the cycle the 4th bit is consumed; `count`=1.
4. **Saturation.** `CNT_W`=2, `PATTERN`=4'b1111, `OVERLAP`=1, eight 1s → five matches; `count` stops at 3; `sat`=1 from the edge after the third match.
5. **Clear vs enable.** Assert `clear` together with `en` on what would be a matching bit → `y`=0 in that cycle; `count`=0, `fill`=0 afterwards; the next match needs 4 new bits.
6. **Asynchronous reset.** Pull `reset_n` low between edges after 1,0,1 → `y_q`, `count` and `sat` drop immediately; after release, stream 1 → no match; full 1,0,1,1 → match.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector family: legal parameter
// ranges, the per-cycle operation encoding and small elaboration helpers.
package seq_det_pkg;

    localparam int W_MIN     = 2;
    localparam int W_MAX     = 16;
    localparam int CNT_W_MIN = 1;
    localparam int CNT_W_MAX = 32;

    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_SHIFT = 2'd1,
        OP_CLEAR = 2'd2
    } seq_op_e;

    // Width of the fill counter, which counts 0..W-1.
    function automatic int fill_width(input int w);
        return $clog2(w);
    endfunction

    function automatic bit params_legal(input int w, input int cnt_w);
        return (w >= W_MIN) && (w <= W_MAX) &&
               (cnt_w >= CNT_W_MIN) && (cnt_w <= CNT_W_MAX);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sat flags the all-ones value.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;

    // NOTE: assign a default first so every path drives the variable and no latch is inferred.
    always_comb begin
        w_count_nxt = r_count;
        if (clear) begin
            w_count_nxt = '0;
        end else if (inc && (r_count != CNT_MAX)) begin
            w_count_nxt = r_count + CNT_W'(1);
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    assign count = r_count;
    assign sat   = (r_count == CNT_MAX);

endmodule

// File: rtl/mealy_seq_detector.sv
// Serial W-bit pattern detector with gated input, overlap option, Mealy match
// pulse, its registered copy and a saturating match counter.
module mealy_seq_detector
    import seq_det_pkg::*;
#(
    parameter int           W       = 4,
    parameter logic [W-1:0] PATTERN = 4'b1011,
    parameter bit           OVERLAP = 1'b1,
    parameter int           CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             a,
    input  logic             clear,
    output logic             y,
    output logic             y_q,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam int                FILL_W   = fill_width(W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(W - 1);

    if (!params_legal(W, CNT_W)) begin : g_bad_params
        $error("mealy_seq_detector: W must be 2..16 and CNT_W 1..32");
    end

    logic [W-2:0]    r_hist;
    logic [FILL_W-1:0] r_fill;
    logic            r_y_q;

    logic [W-2:0]    w_hist_shift;
    logic [W-2:0]    w_hist_nxt;
    logic [FILL_W-1:0] w_fill_nxt;
    logic            w_y_q_nxt;
    logic [W-1:0]    w_window;
    seq_op_e         w_op;

    // With W=2 the history is a single bit, so there is nothing to keep on a shift.
    if (W == 2) begin : g_hist_one
        assign w_hist_shift = a;
    end else begin : g_hist_many
        assign w_hist_shift = {r_hist[W-3:0], a};
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hist <= '0;
            r_fill <= '0;
            r_y_q  <= 1'b0;
        end else begin
            r_hist <= w_hist_nxt;
            r_fill <= w_fill_nxt;
            r_y_q  <= w_y_q_nxt;
        end
    end

    // Next-state logic; clear outranks en.
    always_comb begin
        w_op = OP_HOLD;
        if (clear) begin
            w_op = OP_CLEAR;
        end else if (en) begin
            w_op = OP_SHIFT;
        end
    end

    always_comb begin
        w_hist_nxt = r_hist;
        w_fill_nxt = r_fill;
        w_y_q_nxt  = y;
        unique case (w_op)
            OP_CLEAR: begin
                w_hist_nxt = '0;
                w_fill_nxt = '0;
                w_y_q_nxt  = 1'b0;
            end
            OP_SHIFT: begin
                w_hist_nxt = w_hist_shift;
                if (y && !OVERLAP) begin
                    w_fill_nxt = '0;
                end else if (r_fill != FILL_MAX) begin
                    w_fill_nxt = r_fill + FILL_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Mealy output: the newest bit completes the window without a register.
    always_comb begin
        w_window = {r_hist, a};
        y        = en & ~clear & (r_fill == FILL_MAX) & (w_window == PATTERN);
    end

    assign y_q = r_y_q;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_sat_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .inc     (y),
        .count   (count),
        .sat     (sat)
    );

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Bench for mealy_seq_detector: five parameter variants share one stimulus
// stream and are compared every cycle against a bit-history model.
module tb_mealy_seq_detector;

    localparam int          N        = 5;
    localparam int          P_W[N]   = '{4, 4, 4, 4, 2};
    localparam logic [15:0] P_PAT[N] = '{16'hB, 16'hB, 16'hF, 16'hF, 16'h1};
    localparam bit          P_OV[N]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam int          P_CW[N]  = '{8, 8, 8, 2, 3};

    logic clk;
    logic reset_n;
    logic en;
    logic a;
    logic clear;

    logic [N-1:0] y_a;
    logic [N-1:0] yq_a;
    logic [N-1:0] sat_a;
    logic [31:0]  cnt_a[N];

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int            WG = P_W[g];
        localparam logic [WG-1:0] PG = P_PAT[g][WG-1:0];
        logic [P_CW[g]-1:0] cnt;

        mealy_seq_detector #(
            .W       (WG),
            .PATTERN (PG),
            .OVERLAP (P_OV[g]),
            .CNT_W   (P_CW[g])
        ) u_dut (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (en),
            .a       (a),
            .clear   (clear),
            .y       (y_a[g]),
            .y_q     (yq_a[g]),
            .count   (cnt),
            .sat     (sat_a[g])
        );

        assign cnt_a[g] = 32'(cnt);
    end

    // Model: bits consumed since the last restart plus the most recent bits.
    int          m_seen[N];
    logic [31:0] m_recent[N];
    int          m_cnt[N];
    bit          m_yq[N];

    function automatic int cnt_max(input int i);
        return (1 << P_CW[i]) - 1;
    endfunction

    function automatic bit model_y(input int i);
        logic [31:0] mask;
        logic [31:0] win;
        mask = (32'd1 << P_W[i]) - 32'd1;
        win  = ((m_recent[i] << 1) | 32'(a)) & mask;
        return en && !clear && (m_seen[i] >= P_W[i] - 1) && (win == 32'(P_PAT[i]));
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_seen[i]   = 0;
            m_recent[i] = '0;
            m_cnt[i]    = 0;
            m_yq[i]     = 1'b0;
        end
    endfunction

    always @(negedge reset_n) model_reset();

    always @(posedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < N; i++) begin
                bit yy;
                yy = model_y(i);
                if (clear) begin
                    m_seen[i]   = 0;
                    m_recent[i] = '0;
                    m_cnt[i]    = 0;
                    m_yq[i]     = 1'b0;
                end else begin
                    m_yq[i] = yy;
                    if (en) begin
                        if (yy && (m_cnt[i] < cnt_max(i))) m_cnt[i]++;
                        m_recent[i] = (m_recent[i] << 1) | 32'(a);
                        m_seen[i]   = (yy && !P_OV[i]) ? 0 : m_seen[i] + 1;
                    end
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            check($sformatf("y[%0d]", i),     32'(y_a[i]),   32'(model_y(i)));
            check($sformatf("y_q[%0d]", i),   32'(yq_a[i]),  32'(m_yq[i]));
            check($sformatf("count[%0d]", i), cnt_a[i],      32'(m_cnt[i]));
            check($sformatf("sat[%0d]", i),   32'(sat_a[i]), 32'(m_cnt[i] == cnt_max(i)));
        end
    end

    task automatic drive(input bit e, input bit b, input bit c);
        @(posedge clk);
        #1;
        en    = e;
        a     = b;
        clear = c;
    endtask

    initial begin
        bit t1_a[7]  = '{1, 0, 1, 1, 0, 1, 1};
        bit t1_y0[7] = '{0, 0, 0, 1, 0, 0, 1};
        bit t1_y1[7] = '{0, 0, 0, 1, 0, 0, 0};
        bit t4_y2[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        bit t4_y3[8] = '{0, 0, 0, 1, 1, 1, 1, 1};
        bit t4_s3[8] = '{0, 0, 0, 0, 0, 0, 1, 1};
        bit t3_a[4]  = '{1, 0, 1, 1};
        bit re, rb, rc;

        reset_n = 1'b1;
        en      = 1'b0;
        a       = 1'b0;
        clear   = 1'b0;
        #1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #2;
        check("rst_count", cnt_a[0], 32'd0);
        check("rst_y_q",   32'(yq_a[0]), 32'd0);
        check("rst_sat",   32'(sat_a[3]), 32'd0);

        // Overlapping and non-overlapping 1011
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, t1_a[k], 1'b0);
            #2;
            check("t1_y_ovl",  32'(y_a[0]), 32'(t1_y0[k]));
            check("t1_y_novl", 32'(y_a[1]), 32'(t1_y1[k]));
            if (k > 0) check("t1_yq_ovl", 32'(yq_a[0]), 32'(t1_y0[k-1]));
        end
        drive(1'b0, 1'b0, 1'b0);
        #2;
        check("t1_yq_last", 32'(yq_a[0]), 32'd1);
        check("t1_cnt_ovl",  cnt_a[0], 32'd2);
        check("t1_cnt_novl", cnt_a[1], 32'd1);

        // 1111 non-overlap and saturation of the 2-bit counter
        drive(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b1, 1'b0);
            #2;
            check("t4_y_novl", 32'(y_a[2]),   32'(t4_y2[k]));
            check("t4_y_ovl",  32'(y_a[3]),   32'(t4_y3[k]));
            check("t4_sat",    32'(sat_a[3]), 32'(t4_s3[k]));
        end
        drive(1'b0, 1'b0, 1'b0);
        #2;
        check("t4_cnt_sat",  cnt_a[3], 32'd3);
        check("t4_cnt_novl", cnt_a[2], 32'd2);

        // Enable gaps inside a partial match
        drive(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, t3_a[k], 1'b0);
            #2;
            check("t3_y", 32'(y_a[0]), 32'(k == 3));
            for (int j = 0; j < 3; j++) begin
                drive(1'b0, 1'($urandom_range(1)), 1'b0);
                #2;
                check("t3_y_gap", 32'(y_a[0]), 32'd0);
            end
        end
        check("t3_cnt", cnt_a[0], 32'd1);

        // Clear together with a matching bit
        drive(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) drive(1'b1, t3_a[k], 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        #2;
        check("t5_y_clr", 32'(y_a[0]), 32'd0);
        drive(1'b0, 1'b0, 1'b0);
        #2;
        check("t5_cnt", cnt_a[0], 32'd0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, t3_a[k], 1'b0);
            #2;
            check("t5_y_after", 32'(y_a[0]), 32'(k == 3));
        end

        // Asynchronous reset between edges
        for (int k = 0; k < 6; k++) drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        #1;
        check("t6_yq_pre",  32'(yq_a[3]),  32'd1);
        check("t6_sat_pre", 32'(sat_a[3]), 32'd1);
        reset_n = 1'b0;
        #1;
        check("t6_yq_rst",  32'(yq_a[3]),  32'd0);
        check("t6_cnt_rst", cnt_a[3],      32'd0);
        check("t6_sat_rst", 32'(sat_a[3]), 32'd0);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) drive(1'b1, t3_a[k], 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        #1;
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, t3_a[k], 1'b0);
            #2;
            check("t6_y_after", 32'(y_a[0]), 32'(k == 3));
        end

        // Random traffic with occasional clear and mid-cycle reset
        drive(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4000; k++) begin
            re = ($urandom_range(9) < 7);
            rb = 1'($urandom_range(1));
            rc = ($urandom_range(63) == 0);
            drive(re, rb, rc);
            if ($urandom_range(399) == 0) begin
                #1;
                reset_n = 1'b0;
                #1;
                reset_n = 1'b1;
            end
        end
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
